// File: rtl/heap_alloc_if.sv
// Request / response / memory-write bundle between a requester and the heap allocator.
// master = requester side, slave = allocator side.
interface heap_alloc_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_kind;
    logic [DATA_WIDTH-1:0] req_value;
    logic [ADDR_WIDTH-1:0] req_car;
    logic [ADDR_WIDTH-1:0] req_cdr;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_err;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output req_valid, req_kind, req_value, req_car, req_cdr,
        input  req_ready,
        input  rsp_valid, rsp_addr, rsp_err,
        output rsp_ready,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_value, req_car, req_cdr,
        output req_ready,
        output rsp_valid, rsp_addr, rsp_err,
        input  rsp_ready,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/heap_alloc.sv
// Bump-pointer allocator: builds one tagged object (number, cons, primitive) in object memory
// and returns its header address.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; heap_clear rewinds the free pointer
// WRITE   | emitting object words base+k, one per cycle
// RESP    | presenting rsp_* until rsp_ready; free pointer bumped on entry
module heap_alloc #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = 12'h010,
    parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = 12'hFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    heap_alloc_if.slave           bus,
    input  logic                  heap_clear,
    output logic [ADDR_WIDTH-1:0] free_ptr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [1:0] KIND_NUMBER  = 2'd0;
    localparam logic [1:0] KIND_CONS    = 2'd1;
    localparam logic [1:0] KIND_FUNC    = 2'd2;

    localparam logic [7:0] TYPE_NUMBER    = 8'h00;
    localparam logic [7:0] TYPE_CONS      = 8'h01;
    localparam logic [7:0] TYPE_FUNC_PRIM = 8'h02;

    logic [1:0]            state;
    logic [2:0]            k_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [1:0]            kind_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic [ADDR_WIDTH-1:0] car_q;
    logic [ADDR_WIDTH-1:0] cdr_q;
    logic                  err_q;

    logic                  rsp_valid_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic                  rsp_err_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  req_ready_c;
    logic                  accept;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH:0]   req_end;
    logic [ADDR_WIDTH:0]   limit_end;
    logic                  req_fits;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] word_k;

    function automatic logic [2:0] obj_size(input logic [1:0] kind);
        case (kind)
            KIND_NUMBER: obj_size = 3'd2;
            KIND_CONS:   obj_size = 3'd5;
            KIND_FUNC:   obj_size = 3'd2;
            default:     obj_size = 3'd0;
        endcase
    endfunction

    assign req_ready_c = (state == S_IDLE) && !heap_clear;
    assign accept      = bus.req_valid && req_ready_c;
    assign req_size    = obj_size(bus.req_kind);

    // One extra bit so an object ending exactly past HEAP_LIMIT cannot wrap to look valid.
    assign req_end   = {1'b0, free_ptr} + {{(ADDR_WIDTH-2){1'b0}}, req_size};
    assign limit_end = {1'b0, HEAP_LIMIT} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign req_fits  = (req_end <= limit_end);

    assign last_word = (k_q == (size_q - 3'd1));

    always_comb begin
        word_k = '0;
        case (kind_q)
            KIND_NUMBER: word_k = (k_q == 3'd0) ? TYPE_NUMBER : value_q;
            KIND_FUNC:   word_k = (k_q == 3'd0) ? TYPE_FUNC_PRIM : value_q;
            KIND_CONS: begin
                case (k_q)
                    3'd0:    word_k = TYPE_CONS;
                    3'd1:    word_k = {4'h0, car_q[11:8]};
                    3'd2:    word_k = car_q[7:0];
                    3'd3:    word_k = {4'h0, cdr_q[11:8]};
                    default: word_k = cdr_q[7:0];
                endcase
            end
            default:     word_k = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k_q         <= '0;
            size_q      <= '0;
            base_q      <= '0;
            kind_q      <= '0;
            value_q     <= '0;
            car_q       <= '0;
            cdr_q       <= '0;
            err_q       <= 1'b0;
            free_ptr    <= HEAP_BASE;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (heap_clear) begin
                        free_ptr <= HEAP_BASE;
                    end else if (accept) begin
                        kind_q  <= bus.req_kind;
                        value_q <= bus.req_value;
                        car_q   <= bus.req_car;
                        cdr_q   <= bus.req_cdr;
                        base_q  <= free_ptr;
                        size_q  <= req_size;
                        k_q     <= '0;
                        if ((bus.req_kind == 2'd3) || !req_fits) begin
                            err_q <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= base_q + ADDR_WIDTH'(k_q);
                    mem_wdata_q <= word_k;
                    k_q         <= k_q + 3'd1;
                    if (last_word) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // First RESP cycle publishes the result; later cycles only wait for rsp_ready.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_addr_q  <= err_q ? '0 : base_q;
                        if (!err_q) begin
                            free_ptr <= base_q + ADDR_WIDTH'(size_q);
                        end
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_heap_alloc.sv
// Directed bench for heap_alloc: full heap instance (a) plus a tiny-heap instance (b, limit 0x014).
module tb_heap_alloc;

    logic clk;
    logic rst_n;
    logic sel;

    logic        req_valid;
    logic [1:0]  req_kind;
    logic [7:0]  req_value;
    logic [11:0] req_car;
    logic [11:0] req_cdr;
    logic        rsp_ready;
    logic        heap_clear;

    logic [11:0] free_ptr_a;
    logic [11:0] free_ptr_b;

    heap_alloc_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) if_a ();
    heap_alloc_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) if_b ();

    heap_alloc #(.HEAP_BASE(12'h010), .HEAP_LIMIT(12'hFFF)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_a.slave),
        .heap_clear (heap_clear & ~sel),
        .free_ptr   (free_ptr_a)
    );

    heap_alloc #(.HEAP_BASE(12'h010), .HEAP_LIMIT(12'h014)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_b.slave),
        .heap_clear (heap_clear & sel),
        .free_ptr   (free_ptr_b)
    );

    assign if_a.req_valid = req_valid & ~sel;
    assign if_a.req_kind  = req_kind;
    assign if_a.req_value = req_value;
    assign if_a.req_car   = req_car;
    assign if_a.req_cdr   = req_cdr;
    assign if_a.rsp_ready = rsp_ready;
    assign if_b.req_valid = req_valid & sel;
    assign if_b.req_kind  = req_kind;
    assign if_b.req_value = req_value;
    assign if_b.req_car   = req_car;
    assign if_b.req_cdr   = req_cdr;
    assign if_b.rsp_ready = rsp_ready;

    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_we;
    logic [11:0] o_rsp_addr, o_mem_addr, o_free_ptr;
    logic [7:0]  o_mem_wdata;

    assign o_req_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign o_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign o_rsp_err   = sel ? if_b.rsp_err   : if_a.rsp_err;
    assign o_rsp_addr  = sel ? if_b.rsp_addr  : if_a.rsp_addr;
    assign o_mem_we    = sel ? if_b.mem_we    : if_a.mem_we;
    assign o_mem_addr  = sel ? if_b.mem_addr  : if_a.mem_addr;
    assign o_mem_wdata = sel ? if_b.mem_wdata : if_a.mem_wdata;
    assign o_free_ptr  = sel ? free_ptr_b     : free_ptr_a;

    // Synchronous-write memory model fed by the selected instance.
    logic [7:0] mem [0:4095];
    int         wcount;

    always @(posedge clk) begin
        if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
            wcount          <= wcount + 1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] kind, input logic [7:0] value,
                             input logic [11:0] car, input logic [11:0] cdr);
        req_kind  = kind;
        req_value = value;
        req_car   = car;
        req_cdr   = cdr;
        req_valid = 1'b1;
    endtask

    // Accepted object: size consecutive writes, then response with free pointer bumped.
    task automatic alloc_ok(input string tag, input logic [1:0] kind, input logic [7:0] value,
                            input logic [11:0] car, input logic [11:0] cdr,
                            input logic [11:0] exp_addr, input int size);
        int w0;
        drive_req(kind, value, car, cdr);
        step();
        req_valid = 1'b0;
        w0 = wcount;
        chk({tag, "_ready_low"}, 32'(o_req_ready), 32'd0);
        for (int i = 0; i < size; i++) begin
            step();
            chk({tag, "_we"}, 32'(o_mem_we), 32'd1);
            chk({tag, "_waddr"}, 32'(o_mem_addr), 32'(exp_addr + 12'(i)));
            chk({tag, "_no_rsp_yet"}, 32'(o_rsp_valid), 32'd0);
        end
        step();
        chk({tag, "_we_off"}, 32'(o_mem_we), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({tag, "_rsp_addr"}, 32'(o_rsp_addr), 32'(exp_addr));
        chk({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
        chk({tag, "_free_ptr"}, 32'(o_free_ptr), 32'(exp_addr + 12'(size)));
        chk({tag, "_wcount"}, 32'(wcount - w0), 32'(size));
        step();
        chk({tag, "_rsp_done"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(o_req_ready), 32'd1);
    endtask

    task automatic alloc_err(input string tag, input logic [1:0] kind, input logic [11:0] exp_free);
        int w0;
        drive_req(kind, 8'h00, 12'h000, 12'h000);
        step();
        req_valid = 1'b0;
        w0 = wcount;
        step();
        chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd1);
        chk({tag, "_rsp_addr"}, 32'(o_rsp_addr), 32'd0);
        chk({tag, "_free_ptr"}, 32'(o_free_ptr), 32'(exp_free));
        chk({tag, "_no_we"}, 32'(wcount - w0), 32'd0);
        step();
        chk({tag, "_rsp_done"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, "_no_we_after"}, 32'(wcount - w0), 32'd0);
    endtask

    initial begin
        int w0;
        total      = 0;
        bad        = 0;
        wcount     = 0;
        sel        = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_kind   = 2'd0;
        req_value  = 8'h00;
        req_car    = 12'h000;
        req_cdr    = 12'h000;
        rsp_ready  = 1'b1;
        heap_clear = 1'b0;

        step();
        step();
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_addr", 32'(o_rsp_addr), 32'd0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst_mem_we", 32'(o_mem_we), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
        chk("rst_free_ptr", 32'(o_free_ptr), 32'h010);
        rst_n = 1'b1;
        step();

        alloc_ok("num2a", 2'd0, 8'h2A, 12'h000, 12'h000, 12'h010, 2);
        alloc_ok("cons", 2'd1, 8'h00, 12'h010, 12'h000, 12'h012, 5);
        alloc_ok("prim0", 2'd2, 8'h00, 12'h000, 12'h000, 12'h017, 2);
        chk("mem_010", 32'(mem[12'h010]), 32'h00);
        chk("mem_011", 32'(mem[12'h011]), 32'h2A);
        chk("mem_012", 32'(mem[12'h012]), 32'h01);
        chk("mem_013", 32'(mem[12'h013]), 32'h00);
        chk("mem_014", 32'(mem[12'h014]), 32'h10);
        chk("mem_015", 32'(mem[12'h015]), 32'h00);
        chk("mem_016", 32'(mem[12'h016]), 32'h00);
        chk("mem_017", 32'(mem[12'h017]), 32'h02);
        chk("mem_018", 32'(mem[12'h018]), 32'h00);

        alloc_ok("cons_hi", 2'd1, 8'h00, 12'hABC, 12'h5DE, 12'h019, 5);
        chk("mem_019", 32'(mem[12'h019]), 32'h01);
        chk("mem_01a", 32'(mem[12'h01A]), 32'h0A);
        chk("mem_01b", 32'(mem[12'h01B]), 32'hBC);
        chk("mem_01c", 32'(mem[12'h01C]), 32'h05);
        chk("mem_01d", 32'(mem[12'h01D]), 32'hDE);

        // Illegal kind with response held off for five cycles.
        rsp_ready = 1'b0;
        drive_req(2'd3, 8'h99, 12'h123, 12'h456);
        step();
        req_valid = 1'b0;
        w0 = wcount;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("ill_rsp_valid", 32'(o_rsp_valid), 32'd1);
            chk("ill_rsp_err", 32'(o_rsp_err), 32'd1);
            chk("ill_rsp_addr", 32'(o_rsp_addr), 32'd0);
            chk("ill_req_ready", 32'(o_req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("ill_rsp_done", 32'(o_rsp_valid), 32'd0);
        chk("ill_ready_back", 32'(o_req_ready), 32'd1);
        chk("ill_no_we", 32'(wcount - w0), 32'd0);
        chk("ill_free_ptr", 32'(o_free_ptr), 32'h01E);

        // Reset in the middle of a CONS write.
        drive_req(2'd1, 8'h00, 12'h010, 12'h012);
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mid_we_before", 32'(o_mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we_async", 32'(o_mem_we), 32'd0);
        chk("mid_free_ptr", 32'(o_free_ptr), 32'h010);
        chk("mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_no_rsp", 32'(o_rsp_valid), 32'd0);
        alloc_ok("after_rst", 2'd0, 8'h77, 12'h000, 12'h000, 12'h010, 2);
        chk("mem_010_b", 32'(mem[12'h010]), 32'h00);
        chk("mem_011_b", 32'(mem[12'h011]), 32'h77);

        // heap_clear in IDLE blocks acceptance and rewinds the pointer.
        heap_clear = 1'b1;
        drive_req(2'd0, 8'h11, 12'h000, 12'h000);
        #1;
        chk("clr_ready_low", 32'(o_req_ready), 32'd0);
        w0 = wcount;
        step();
        heap_clear = 1'b0;
        req_valid  = 1'b0;
        chk("clr_free_ptr", 32'(o_free_ptr), 32'h010);
        step();
        chk("clr_no_accept", 32'(o_rsp_valid), 32'd0);
        chk("clr_no_we", 32'(wcount - w0), 32'd0);

        // heap_clear while writing is ignored.
        drive_req(2'd0, 8'h33, 12'h000, 12'h000);
        step();
        req_valid  = 1'b0;
        heap_clear = 1'b1;
        step();
        step();
        step();
        chk("clrw_rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("clrw_rsp_addr", 32'(o_rsp_addr), 32'h010);
        chk("clrw_free_ptr", 32'(o_free_ptr), 32'h012);
        heap_clear = 1'b0;
        step();
        chk("clrw_rsp_done", 32'(o_rsp_valid), 32'd0);
        chk("clrw_mem_011", 32'(mem[12'h011]), 32'h33);

        // Tiny heap: 0x010..0x014.
        sel = 1'b1;
        #1;
        chk("b_free_ptr_init", 32'(o_free_ptr), 32'h010);
        alloc_ok("b_num", 2'd0, 8'h55, 12'h000, 12'h000, 12'h010, 2);
        alloc_err("b_cons_over", 2'd1, 12'h012);
        alloc_ok("b_num_fit", 2'd0, 8'h66, 12'h000, 12'h000, 12'h012, 2);
        alloc_err("b_num_over", 2'd0, 12'h014);
        chk("b_mem_013", 32'(mem[12'h013]), 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
